imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the instruction memory the single-cycle RISC-V datapath fetches from. It accepts a byte stream over a valid/ready handshake, reads a 16-bit little-endian word count, and assembles the following payload into 32-bit little-endian instructions. It writes each instruction through the instruction memory's write port at consecutive word addresses, and holds the CPU in reset until the load completes.

## Interface
- `INS_W`, 32, instruction width; fixed at 4 bytes per word
- `IM_ADDRESS`, 9, instruction memory word-address width; depth is 2**IM_ADDRESS words
- `CNT_W`, 16, word-count width
- `clk`  in  1  global clock
- `reset`  in  1  one clock; reset is asynchronous and active-high
- `start`  in  1  single-cycle request to begin a load
- `rx_data`  in  8  stream byte
- `rx_valid`  in  1  `rx_data` is valid
- `rx_ready`  out  1  loader accepts a byte this cycle
- `im_we`  out  1  instruction memory write enable
- `im_addr`  out  IM_ADDRESS  word address of the write
- `im_wdata`  out  INS_W  instruction to write
- `cpu_hold`  out  1  held high to keep the datapath in reset
- `load_done`  out  1  one-cycle pulse when a load finishes
- `overflow`  out  1  sticky; count exceeded memory depth
- `words_loaded`  out  CNT_W  number of words received in the current or last load

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, FLUSH, DONE.
- A byte transfer occurs on a rising edge with `rx_valid & rx_ready`.
- **IDLE** (reset state):
  - `cpu_hold`=1, `rx_ready`=0.
  - `start` moves to LEN_LO.
- **LEN_LO / LEN_HI**:
  - `rx_ready`=1.
  - The accepted byte becomes count[7:0] in LEN_LO and count[15:8] in LEN_HI.
  - On the LEN_HI byte: go to DONE if the count is 0, otherwise to DATA.
- **Load start**: entering LEN_LO clears `words_loaded`, `overflow` and the byte index.
- **DATA**:
  - `rx_ready`=1.
  - The byte index (0..3) selects the destination byte lane: byte k goes to bits [8k+7:8k].
  - On lane 3: `im_we` asserts next cycle with the assembled word, `im_addr` = word index, and `words_loaded` increments.
  - If that write is the count-th word, go to FLUSH.
- **Overflow**:
  - A word whose index is ≥ 2**IM_ADDRESS is consumed with `im_we` suppressed, and `overflow` is set.
  - `im_addr` never wraps.
- **FLUSH**: one cycle with `rx_ready`=0, then DONE. This guarantees the final write has landed before the CPU is released.
- **DONE**:
  - `cpu_hold`=0, `rx_ready`=0.
  - `load_done` pulses on the first cycle of DONE only.
  - `start` returns to LEN_LO, which reasserts `cpu_hold` in that same cycle.
- `start` outside IDLE/DONE is ignored.
- Bytes offered while `rx_ready`=0 are not consumed.

## Timing
- **Reset values**:
  - state IDLE, `cpu_hold`=1
  - `rx_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0
  - `load_done`=0, `overflow`=0, `words_loaded`=0
- **Reset mid-load**: returns immediately to reset values and discards any partial word. Memory words already written are not touched.
- All outputs are registered.
- `im_we` is high for exactly one cycle per stored word, in the cycle after lane 3 is accepted.
- **Final-word sequence**: lane-3 byte of the last word accepted at edge N.
  - cycle N+1: `im_we`=1 and state FLUSH.
  - cycle N+2: DONE, `cpu_hold`=0, `load_done`=1.
- **Throughput**: 1 byte/cycle sustained. A write and the next byte's acceptance may occur in the same cycle.
- **Back-to-back**: `start` asserted during the `load_done` cycle is honored.
- **Stalls**: bubbles on `rx_valid` stall without affecting assembled lanes.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_t`
  - constants `LEN_BYTES`=2 and `BYTES_PER_WORD`=4
- Sub-module `word_assembler`:
  - 2-bit lane counter plus 32-bit lane register
  - inputs `clk`, `reset`, `clr`, `byte_en`, `byte_in`
  - outputs `word_out`, `word_valid`
- The top level holds the FSM, address/count counters, overflow logic and output registers.

## Test plan
- **Reset**: reset asserted mid-DATA after 2 bytes of a word → all outputs at reset values, no `im_we`. A subsequent `start` with count 1 and bytes 13 00 00 00 → `im_addr`=0, `im_wdata`=0x00000013.
- **Nominal load**: `start`, count bytes 02 00, then 93 00 50 00 13 01 A0 00 →
  - writes 0x00500093 at address 0 and 0x00A00113 at address 1
  - `load_done` two cycles after the last byte, `cpu_hold` falls the same cycle, `words_loaded`=2
- **Zero count**: `start`, 00 00 → DONE directly, `load_done` pulses, no `im_we`.
- **Backpressure and bubbles**: random `rx_valid` gaps, plus bytes offered in IDLE → identical memory image, IDLE bytes not consumed.
- **Overflow** with IM_ADDRESS=2: count 5, 20 bytes → writes at addresses 0–3 only, `overflow`=1, `words_loaded`=5, `im_addr` never exceeds 3.
- **Reload**: `start` in the `load_done` cycle → `cpu_hold` rises, `overflow` and `words_loaded` clear, second image overwrites from address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_FLUSH,
        S_DONE
    } loader_state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into instruction words, one lane per accepted byte.
module word_assembler
    import loader_pkg::*;
#(
    parameter int INS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             byte_en,
    input  logic [7:0]       byte_in,
    output logic [INS_W-1:0] word_out,
    output logic             word_valid
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [INS_W-1:0]  word_q, word_d;

    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        if (clr) begin
            lane_d = '0;
            word_d = '0;
        end else if (byte_en) begin
            word_d[8*int'(lane_q) +: 8] = byte_in;
            lane_d = lane_q + LANE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

    // The top byte bypasses the lane register so the word is complete in the accepting cycle.
    assign word_valid = byte_en && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    assign word_out   = {byte_in, word_q[INS_W-9:0]};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a 16-bit word count, streams the payload into instruction memory,
// and holds the CPU in reset until the final write has landed.
module imem_loader
    import loader_pkg::*;
#(
    parameter int INS_W      = 32,
    parameter int IM_ADDRESS = 9,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  im_we,
    output logic [IM_ADDRESS-1:0] im_addr,
    output logic [INS_W-1:0]      im_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  overflow,
    output logic [CNT_W-1:0]      words_loaded
);

    loader_state_t         state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      words_loaded_q, words_loaded_d;
    logic                  overflow_q, overflow_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  im_we_q, im_we_d;
    logic [IM_ADDRESS-1:0] im_addr_q, im_addr_d;
    logic [INS_W-1:0]      im_wdata_q, im_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;

    logic             xfer;
    logic             clr;
    logic             byte_en;
    logic [INS_W-1:0] word_out;
    logic             word_valid;
    logic             in_range;

    assign xfer     = rx_valid && rx_ready_q;
    assign byte_en  = xfer && (state_q == S_DATA);
    assign in_range = (words_loaded_q >> IM_ADDRESS) == '0;

    word_assembler #(.INS_W(INS_W)) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .byte_en    (byte_en),
        .byte_in    (rx_data),
        .word_out   (word_out),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        words_loaded_d = words_loaded_q;
        overflow_d     = overflow_q;
        im_addr_d      = im_addr_q;
        im_wdata_d     = im_wdata_q;
        im_we_d        = 1'b0;
        clr            = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d        = S_LEN_LO;
                    clr            = 1'b1;
                    count_d        = '0;
                    words_loaded_d = '0;
                    overflow_d     = 1'b0;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    count_d[7:0] = rx_data;
                    state_d      = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    count_d = CNT_W'({rx_data, count_q[7:0]});
                    state_d = (count_d == '0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (word_valid) begin
                    words_loaded_d = words_loaded_q + CNT_W'(1);
                    // Words past the memory depth are swallowed; the address stays put.
                    if (in_range) begin
                        im_we_d    = 1'b1;
                        im_addr_d  = words_loaded_q[IM_ADDRESS-1:0];
                        im_wdata_d = word_out;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (words_loaded_d == count_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        rx_ready_d  = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
        cpu_hold_d  = (state_d != S_DONE);
        load_done_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            words_loaded_q <= '0;
            overflow_q     <= 1'b0;
            rx_ready_q     <= 1'b0;
            im_we_q        <= 1'b0;
            im_addr_q      <= '0;
            im_wdata_q     <= '0;
            cpu_hold_q     <= 1'b1;
            load_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            words_loaded_q <= words_loaded_d;
            overflow_q     <= overflow_d;
            rx_ready_q     <= rx_ready_d;
            im_we_q        <= im_we_d;
            im_addr_q      <= im_addr_d;
            im_wdata_q     <= im_wdata_d;
            cpu_hold_q     <= cpu_hold_d;
            load_done_q    <= load_done_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign overflow     = overflow_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word memory so overflow is reachable.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        im_we;
    logic [1:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        overflow;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [1:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    typedef struct {
        int                cnt;
        bit                gaps;
        logic [0:19][7:0]  b;
        int                exp_wl;
        bit                exp_ovf;
        int                exp_nwr;
        logic [0:3][31:0]  exp_mem;
    } vec_t;

    vec_t vecs[4];

    imem_loader #(.INS_W(32), .IM_ADDRESS(2), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .overflow     (overflow),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rx_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit sent;
        sent = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data = b;
            if (rx_ready === 1'b1) begin
                @(posedge clk);
                sent = 1'b1;
                break;
            end
        end
        if (!sent) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h never accepted", b);
        end
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            if (load_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        chk({nm, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({nm, "_im_we"}, {31'd0, im_we}, 32'd0);
        chk({nm, "_im_addr"}, {30'd0, im_addr}, 32'd0);
        chk({nm, "_im_wdata"}, im_wdata, 32'd0);
        chk({nm, "_load_done"}, {31'd0, load_done}, 32'd0);
        chk({nm, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({nm, "_words_loaded"}, {16'd0, words_loaded}, 32'd0);
    endtask

    task automatic run_vec(input int i);
        string nm;
        nm = $sformatf("vec%0d", i);
        wr_addr.delete();
        wr_data.delete();
        repeat (2) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data = 8'hFF;
            chk({nm, "_idle_not_ready"}, {31'd0, rx_ready}, 32'd0);
        end
        pulse_start();
        send_byte(vecs[i].cnt[7:0], 0);
        send_byte(vecs[i].cnt[15:8], 0);
        for (int k = 0; k < 4 * vecs[i].cnt; k++) begin
            send_byte(vecs[i].b[k], vecs[i].gaps ? int'($urandom_range(0, 2)) : 0);
        end
        wait_done(nm);
        chk({nm, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({nm, "_words_loaded"}, {16'd0, words_loaded}, vecs[i].exp_wl);
        chk({nm, "_overflow"}, {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
        chk({nm, "_nwrites"}, wr_addr.size(), vecs[i].exp_nwr);
        for (int k = 0; k < wr_addr.size() && k < vecs[i].exp_nwr; k++) begin
            chk($sformatf("%s_addr%0d", nm, k), {30'd0, wr_addr[k]}, k);
            chk($sformatf("%s_data%0d", nm, k), wr_data[k], vecs[i].exp_mem[k]);
        end
    endtask

    initial begin
        vecs[0].cnt = 2; vecs[0].gaps = 1'b0;
        vecs[0].b = {8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 96'h0};
        vecs[0].exp_wl = 2; vecs[0].exp_ovf = 1'b0; vecs[0].exp_nwr = 2;
        vecs[0].exp_mem = {32'h00500093, 32'h00A00113, 64'h0};

        vecs[1] = vecs[0];
        vecs[1].gaps = 1'b1;

        vecs[2].cnt = 0; vecs[2].gaps = 1'b0; vecs[2].b = '0;
        vecs[2].exp_wl = 0; vecs[2].exp_ovf = 1'b0; vecs[2].exp_nwr = 0;
        vecs[2].exp_mem = '0;

        vecs[3].cnt = 5; vecs[3].gaps = 1'b1;
        for (int k = 0; k < 20; k++) vecs[3].b[k] = 8'(k);
        vecs[3].exp_wl = 5; vecs[3].exp_ovf = 1'b1; vecs[3].exp_nwr = 4;
        vecs[3].exp_mem = {32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;

        // Reset in the middle of a word: partial bytes are discarded, nothing written.
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_no_write", wr_addr.size(), 0);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_done("postrst");
        chk("postrst_nwr", wr_addr.size(), 1);
        if (wr_addr.size() > 0) begin
            chk("postrst_addr", {30'd0, wr_addr[0]}, 0);
            chk("postrst_data", wr_data[0], 32'h00000013);
        end

        // Final-word timing: write in N+1, load_done and cpu release in N+2.
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h01, 0);
        send_byte(8'hA0, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("tim_n1_im_we", {31'd0, im_we}, 32'd1);
        chk("tim_n1_addr", {30'd0, im_addr}, 32'd1);
        chk("tim_n1_wdata", im_wdata, 32'h00A00113);
        chk("tim_n1_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("tim_n1_load_done", {31'd0, load_done}, 32'd0);
        chk("tim_n1_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        @(negedge clk);
        chk("tim_n2_load_done", {31'd0, load_done}, 32'd1);
        chk("tim_n2_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("tim_n2_im_we", {31'd0, im_we}, 32'd0);
        chk("tim_n2_words", {16'd0, words_loaded}, 32'd2);
        @(negedge clk);
        chk("tim_n3_load_done", {31'd0, load_done}, 32'd0);
        chk("tim_n3_cpu_hold", {31'd0, cpu_hold}, 32'd0);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Restart issued in the load_done cycle that ended the overflow load.
        wr_addr.delete();
        wr_data.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reload_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("reload_overflow", {31'd0, overflow}, 32'd0);
        chk("reload_words", {16'd0, words_loaded}, 32'd0);
        chk("reload_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        wait_done("reload");
        chk("reload_nwr", wr_addr.size(), 1);
        if (wr_addr.size() > 0) begin
            chk("reload_addr", {30'd0, wr_addr[0]}, 0);
            chk("reload_data", wr_data[0], 32'hDEADBEEF);
        end
        chk("reload_words_end", {16'd0, words_loaded}, 32'd1);
        chk("reload_overflow_end", {31'd0, overflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
